// File: rtl/rv32i_pkg.sv
// Shared data-memory request types and widths for the dual-issue core.
package rv32i_pkg;

  localparam int unsigned DMEM_AW  = 32;
  localparam int unsigned DMEM_DW  = 32;
  localparam int unsigned DMEM_BEW = DMEM_DW / 8;

  typedef struct packed {
    logic [DMEM_AW-1:0]  addr;
    logic [DMEM_DW-1:0]  wdata;
    logic [DMEM_BEW-1:0] be;
    logic                re;
  } dmem_req_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_HOLD
  } arb_state_e;

endpackage

// File: rtl/dmem_hold_buf.sv
// One-entry parking register for a slot1 request that lost arbitration.
module dmem_hold_buf
  import rv32i_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      clear,
  input  dmem_req_t d,
  output dmem_req_t q,
  output logic      valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between execute slot0 and slot1; slot0 always wins.
// Optional statistics counters are enabled with DMEM_ARB_STATS_EN.
module dmem_port_arbiter
  import rv32i_pkg::*;
#(
  parameter int unsigned AW  = DMEM_AW,
  parameter int unsigned DW  = DMEM_DW,
  parameter int unsigned BEW = DMEM_BEW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  dmem_req_t      req0,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  dmem_req_t      req1,
  output logic           stall,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  output logic [DW-1:0]  rsp_rdata,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  output logic [BEW-1:0] mem_we,
  output logic           mem_re,
  input  logic [DW-1:0]  mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]    stat_grant0,
  output logic [31:0]    stat_grant1,
  output logic [31:0]    stat_conflict
`endif
);

  arb_state_e state_q, state_d;
  dmem_req_t  port_req, hold_q;
  logic       port_valid, port_owner1;
  logic       hold_load, hold_clear, hold_valid;
  logic       tag0_q, tag1_q;

  dmem_hold_buf u_hold_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (hold_load),
    .clear (hold_clear),
    .d     (req1),
    .q     (hold_q),
    .valid (hold_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset is folded in so the port goes quiet the instant rst rises.
  always_comb begin
    state_d     = state_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    stall       = 1'b0;
    port_req    = '0;
    port_valid  = 1'b0;
    port_owner1 = 1'b0;
    hold_load   = 1'b0;
    hold_clear  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ARB_IDLE: begin
          req0_ready = 1'b1;
          req1_ready = 1'b1;
          if (req0_valid) begin
            port_req   = req0;
            port_valid = 1'b1;
            if (req1_valid && !flush) begin
              hold_load = 1'b1;
              state_d   = ARB_HOLD;
            end
          end else if (req1_valid && !flush) begin
            port_req    = req1;
            port_valid  = 1'b1;
            port_owner1 = 1'b1;
          end
        end
        ARB_HOLD: begin
          stall      = 1'b1;
          hold_clear = 1'b1;
          state_d    = ARB_IDLE;
          if (!flush && hold_valid) begin
            port_req    = hold_q;
            port_valid  = 1'b1;
            port_owner1 = 1'b1;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  assign mem_addr  = port_req.addr;
  assign mem_wdata = port_req.wdata;
  assign mem_we    = port_req.be;
  assign mem_re    = port_req.re;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag0_q <= 1'b0;
      tag1_q <= 1'b0;
    end else begin
      tag0_q <= port_valid && port_req.re && !port_owner1;
      tag1_q <= port_valid && port_req.re && port_owner1;
    end
  end

  // A redirect in the response cycle still kills the younger slot's data.
  assign rsp0_valid = tag0_q;
  assign rsp1_valid = tag1_q && !flush;
  assign rsp_rdata  = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (port_valid && !port_owner1) stat_grant0 <= stat_grant0 + 32'd1;
      if (port_valid && port_owner1)  stat_grant1 <= stat_grant1 + 32'd1;
      if (hold_load)                  stat_conflict <= stat_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level schedule model and a reference memory.
module tb_dmem_port_arbiter;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  dmem_req_t   r0 = '0, r1 = '0;
  logic        req0_ready, req1_ready, stall, rsp0_valid, rsp1_valid, mem_re;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_grant0, stat_grant1, stat_conflict;
`endif

  int compared = 0;
  int failed = 0;

  dmem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req0_valid (v0),
    .req0_ready (req0_ready),
    .req0       (r0),
    .req1_valid (v1),
    .req1_ready (req1_ready),
    .req1       (r1),
    .stall      (stall),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_rdata  (rsp_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_grant0   (stat_grant0),
    .stat_grant1   (stat_grant1),
    .stat_conflict (stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous memory with a backdoor preload path.
  logic [31:0] tb_mem [256];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= tb_mem[mem_addr[9:2]];
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) tb_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (bd_we) tb_mem[bd_idx] <= bd_data;
  end

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic drive_idle();
    v0 = 1'b0; v1 = 1'b0; flush = 1'b0; r0 = '0; r1 = '0;
  endtask

  function automatic dmem_req_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [3:0] be, input logic re);
    dmem_req_t r;
    r.addr = addr; r.wdata = wdata; r.be = be; r.re = re;
    return r;
  endfunction

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    #12;
    compared++;
    if ({stall, rsp0_valid, rsp1_valid, mem_re, mem_we, mem_addr, mem_wdata} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got stall=%b rsp0=%b rsp1=%b re=%b we=%h addr=%h wdata=%h, want all 0",
               stall, rsp0_valid, rsp1_valid, mem_re, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single_load();
    logic saw_stall;
    preload(8'h40, 32'hDEADBEEF);
    @(posedge clk); #1;
    drive_idle(); v0 = 1'b1; r0 = mk(32'h100, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    saw_stall = stall;
    compared++;
    if (!(mem_re === 1'b1 && mem_addr === 32'h100 && req0_ready === 1'b1)) begin
      failed++;
      $display("FAIL single_load_issue: re=%b addr=%h rdy0=%b, want re=1 addr=100 rdy0=1",
               mem_re, mem_addr, req0_ready);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    saw_stall = saw_stall | stall;
    compared++;
    if (!(rsp0_valid === 1'b1 && rsp1_valid === 1'b0 && rsp_rdata === 32'hDEADBEEF)) begin
      failed++;
      $display("FAIL single_load_rsp: rsp0=%b rsp1=%b rdata=%h, want 1 0 deadbeef",
               rsp0_valid, rsp1_valid, rsp_rdata);
    end
    compared++;
    if (saw_stall !== 1'b0) begin
      failed++;
      $display("FAIL single_load_stall: stall=%b, want 0", saw_stall);
    end
  endtask

  task automatic test_conflict();
    @(posedge clk); #1;
    drive_idle();
    v0 = 1'b1; r0 = mk(32'h200, 32'h11223344, 4'hF, 1'b0);
    v1 = 1'b1; r1 = mk(32'h200, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    compared++;
    if (!(mem_we === 4'hF && mem_re === 1'b0 && mem_addr === 32'h200 &&
          mem_wdata === 32'h11223344 && stall === 1'b0 && req1_ready === 1'b1)) begin
      failed++;
      $display("FAIL conflict_cycle_n: we=%h re=%b addr=%h wdata=%h stall=%b rdy1=%b, want F 0 200 11223344 0 1",
               mem_we, mem_re, mem_addr, mem_wdata, stall, req1_ready);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    compared++;
    if (!(stall === 1'b1 && mem_re === 1'b1 && mem_we === 4'h0 && mem_addr === 32'h200 &&
          req0_ready === 1'b0 && req1_ready === 1'b0)) begin
      failed++;
      $display("FAIL conflict_replay: stall=%b re=%b we=%h addr=%h rdy=%b%b, want 1 1 0 200 00",
               stall, mem_re, mem_we, mem_addr, req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    compared++;
    if (!(rsp1_valid === 1'b1 && rsp0_valid === 1'b0 && rsp_rdata === 32'h11223344 &&
          stall === 1'b0)) begin
      failed++;
      $display("FAIL conflict_rsp: rsp1=%b rsp0=%b rdata=%h stall=%b, want 1 0 11223344 0",
               rsp1_valid, rsp0_valid, rsp_rdata, stall);
    end
  endtask

  task automatic test_flush_hold();
    @(posedge clk); #1;
    drive_idle();
    v0 = 1'b1; r0 = mk(32'h240, 32'hA5A5A5A5, 4'hF, 1'b0);
    v1 = 1'b1; r1 = mk(32'h240, 32'h0, 4'h0, 1'b1);
    @(posedge clk); #1;
    drive_idle(); flush = 1'b1;
    @(negedge clk);
    compared++;
    if (!(mem_re === 1'b0 && mem_we === 4'h0 && stall === 1'b1)) begin
      failed++;
      $display("FAIL flush_hold_port: re=%b we=%h stall=%b, want 0 0 1", mem_re, mem_we, stall);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    compared++;
    if (!(rsp1_valid === 1'b0 && stall === 1'b0 && req0_ready === 1'b1 && req1_ready === 1'b1)) begin
      failed++;
      $display("FAIL flush_hold_after: rsp1=%b stall=%b rdy=%b%b, want 0 0 11",
               rsp1_valid, stall, req0_ready, req1_ready);
    end
  endtask

  task automatic test_flush_idle();
    preload(8'hC0, 32'hCAFEF00D);
    preload(8'hC1, 32'h0BADF00D);
    @(posedge clk); #1;
    drive_idle(); flush = 1'b1;
    v0 = 1'b1; r0 = mk(32'h304, 32'h0, 4'h0, 1'b1);
    v1 = 1'b1; r1 = mk(32'h300, 32'h12345678, 4'hF, 1'b0);
    @(negedge clk);
    compared++;
    if (!(mem_re === 1'b1 && mem_we === 4'h0 && mem_addr === 32'h304 && req1_ready === 1'b1 &&
          stall === 1'b0)) begin
      failed++;
      $display("FAIL flush_idle_issue: re=%b we=%h addr=%h rdy1=%b stall=%b, want 1 0 304 1 0",
               mem_re, mem_we, mem_addr, req1_ready, stall);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    compared++;
    if (!(rsp0_valid === 1'b1 && rsp_rdata === 32'h0BADF00D && stall === 1'b0 &&
          mem_we === 4'h0 && mem_re === 1'b0)) begin
      failed++;
      $display("FAIL flush_idle_next: rsp0=%b rdata=%h stall=%b we=%h re=%b, want 1 0badf00d 0 0 0",
               rsp0_valid, rsp_rdata, stall, mem_we, mem_re);
    end
    @(posedge clk); #1;
    compared++;
    if (tb_mem[8'hC0] !== 32'hCAFEF00D) begin
      failed++;
      $display("FAIL flush_idle_mem: mem[300]=%h, want cafef00d", tb_mem[8'hC0]);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    drive_idle();
    v0 = 1'b1; r0 = mk(32'h208, 32'h55667788, 4'hF, 1'b0);
    v1 = 1'b1; r1 = mk(32'h20C, 32'h0, 4'h0, 1'b1);
    @(posedge clk); #1;
    drive_idle();
    #1 rst = 1'b1;
    #1;
    compared++;
    if ({stall, rsp0_valid, rsp1_valid, mem_re, mem_we, mem_addr, mem_wdata} !== '0) begin
      failed++;
      $display("FAIL async_reset: stall=%b rsp0=%b rsp1=%b re=%b we=%h addr=%h wdata=%h, want all 0",
               stall, rsp0_valid, rsp1_valid, mem_re, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #3 rst = 1'b0;
    @(negedge clk);
    compared++;
    if (!(mem_re === 1'b0 && stall === 1'b0)) begin
      failed++;
      $display("FAIL async_reset_no_replay: re=%b stall=%b, want 0 0", mem_re, stall);
    end
    @(posedge clk); #1;
    v1 = 1'b1; r1 = mk(32'h208, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    compared++;
    if (!(mem_re === 1'b1 && mem_addr === 32'h208 && stall === 1'b0 && req1_ready === 1'b1)) begin
      failed++;
      $display("FAIL async_reset_req1: re=%b addr=%h stall=%b rdy1=%b, want 1 208 0 1",
               mem_re, mem_addr, stall, req1_ready);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    compared++;
    if (!(rsp1_valid === 1'b1 && rsp_rdata === 32'h55667788)) begin
      failed++;
      $display("FAIL async_reset_rsp: rsp1=%b rdata=%h, want 1 55667788", rsp1_valid, rsp_rdata);
    end
  endtask

  function automatic dmem_req_t rand_req();
    logic [7:0]  idx;
    int unsigned kind;
    idx  = 8'($urandom);
    kind = $urandom_range(0, 2);
    case (kind)
      0:       return mk({22'd0, idx, 2'b00}, 32'h0, 4'h0, 1'b1);
      1:       return mk({22'd0, idx, 2'b00}, $urandom, 4'($urandom_range(1, 15)), 1'b0);
      default: return mk({22'd0, idx, 2'b00}, 32'h0, 4'h0, 1'b0);
    endcase
  endfunction

  // Model: a slot1 request that loses to slot0 is scheduled into the following cycle,
  // which is reserved (stall, no new acceptances); reads answer one cycle after the port.
  task automatic test_random();
    logic [31:0] ref_mem [256];
    logic        reserved, new_reserved, hold0, hold1, rsp_pend, rsp_own;
    dmem_req_t   res_op, new_op, e_op;
    logic        e_port, e_own, e_rsp0, e_rsp1;
    logic [31:0] rsp_data;
    logic [11:0] e_ctrl, got_ctrl;
    logic [7:0]  idx;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      preload(8'(i), ref_mem[i]);
    end
    reserved = 1'b0; hold0 = 1'b0; hold1 = 1'b0; rsp_pend = 1'b0; rsp_own = 1'b0;
    res_op = '0; rsp_data = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge clk); #1;
      if (!hold0) begin v0 = ($urandom_range(0, 99) < 50); r0 = rand_req(); end
      if (!hold1) begin v1 = ($urandom_range(0, 99) < 50); r1 = rand_req(); end
      flush = ($urandom_range(0, 99) < 12);
      @(negedge clk);
      e_port = 1'b0; e_op = '0; e_own = 1'b0; new_reserved = 1'b0; new_op = '0;
      if (reserved) begin
        if (!flush) begin e_port = 1'b1; e_op = res_op; e_own = 1'b1; end
      end else if (v0) begin
        e_port = 1'b1; e_op = r0;
        if (v1 && !flush) begin new_reserved = 1'b1; new_op = r1; end
      end else if (v1 && !flush) begin
        e_port = 1'b1; e_op = r1; e_own = 1'b1;
      end
      e_rsp0 = rsp_pend && !rsp_own;
      e_rsp1 = rsp_pend && rsp_own && !flush;
      e_ctrl   = {reserved, !reserved, !reserved, e_rsp0, e_rsp1, e_op.re, e_op.be, 2'b00};
      got_ctrl = {stall, req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_re, mem_we, 2'b00};
      compared++;
      if (got_ctrl !== e_ctrl) begin
        failed++;
        $display("FAIL rand_ctrl cyc %0d: {stall,rdy0,rdy1,rsp0,rsp1,re,we} got %b want %b",
                 cyc, got_ctrl[11:2], e_ctrl[11:2]);
      end
      if (e_rsp0 || e_rsp1) begin
        compared++;
        if (rsp_rdata !== rsp_data) begin
          failed++;
          $display("FAIL rand_rdata cyc %0d: got %h want %h", cyc, rsp_rdata, rsp_data);
        end
      end
      if (e_port && (e_op.re || e_op.be != 4'h0)) begin
        compared++;
        if (mem_addr !== e_op.addr || (e_op.be != 4'h0 && mem_wdata !== e_op.wdata)) begin
          failed++;
          $display("FAIL rand_port cyc %0d: addr/wdata got %h/%h want %h/%h",
                   cyc, mem_addr, mem_wdata, e_op.addr, e_op.wdata);
        end
      end
      idx = e_op.addr[9:2];
      rsp_pend = e_port && e_op.re;
      rsp_own  = e_own;
      rsp_data = ref_mem[idx];
      if (e_port)
        for (int b = 0; b < 4; b++)
          if (e_op.be[b]) ref_mem[idx][8*b +: 8] = e_op.wdata[8*b +: 8];
      hold0    = v0 && reserved;
      hold1    = v1 && reserved;
      reserved = new_reserved;
      res_op   = new_op;
    end
    @(posedge clk); #1;
    drive_idle();
    repeat (2) @(posedge clk);
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    @(posedge clk); #1;
    drive_idle(); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      v0 = 1'b1; r0 = mk(32'h10 + 32'(i * 4), 32'h0, 4'h0, 1'b1);
      v1 = 1'b1; r1 = mk(32'h20 + 32'(i * 4), 32'h0, 4'h0, 1'b1);
      @(posedge clk); #1;
      drive_idle();
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      v0 = 1'b1; r0 = mk(32'h40, 32'hFFFF0000, 4'h3, 1'b0);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    compared++;
    if (!(stat_grant0 === 32'd5 && stat_grant1 === 32'd3 && stat_conflict === 32'd3)) begin
      failed++;
      $display("FAIL stats: grant0=%0d grant1=%0d conflict=%0d, want 5 3 3",
               stat_grant0, stat_grant1, stat_conflict);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_load();
    test_conflict();
    test_flush_hold();
    test_flush_idle();
    test_async_reset();
    test_random();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
